// File: rtl/lifo_pkg.sv
// Shared definitions for the parametrised LIFO: operation codes and width helpers.
package lifo_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_IDLE    = 3'd0;
  localparam logic [OP_W-1:0] OP_PUSH    = 3'd1;
  localparam logic [OP_W-1:0] OP_POP     = 3'd2;
  localparam logic [OP_W-1:0] OP_REPLACE = 3'd3;
  localparam logic [OP_W-1:0] OP_PEEK    = 3'd4;

  // Width needed to hold an occupancy of 0..depth
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Push/pop select the operation first; peek only matters when both are low
  function automatic logic [OP_W-1:0] decode_op(input logic push, input logic pop,
                                                input logic peek);
    logic [OP_W-1:0] op;
    if (push && pop)  op = OP_REPLACE;
    else if (push)    op = OP_PUSH;
    else if (pop)     op = OP_POP;
    else if (peek)    op = OP_PEEK;
    else              op = OP_IDLE;
    return op;
  endfunction

endpackage

// File: rtl/lifo_mem_1w1r.sv
// Register array with one synchronous write port and one asynchronous read port.
module lifo_mem_1w1r #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_W     = 3
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata_c
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Storage is intentionally not reset; only entries below the count are ever read
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Combinational read of the current top entry
  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with replace-top, peek, occupancy and sticky error flags.
module lifo_stack_param
  import lifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned DEPTH      = 8,
  parameter  int unsigned AF_MARGIN  = 1,
  localparam int unsigned CNT_W      = cnt_w(DEPTH)
) (
  input  logic                  Clk_In,
  input  logic                  Reset_N_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Push_In,
  input  logic                  Pop_In,
  input  logic                  Peek_In,
  input  logic                  Err_Clr_In,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Out_Valid,
  output logic [CNT_W-1:0]      Count,
  output logic                  LIFO_Empty,
  output logic                  LIFO_Full,
  output logic                  Almost_Full,
  output logic                  Overflow_Err,
  output logic                  Underflow_Err
);

  localparam int unsigned     ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(DEPTH - AF_MARGIN);

  logic [OP_W-1:0]       w_op;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_we;
  logic [ADDR_W-1:0]     w_waddr;
  logic [ADDR_W-1:0]     w_raddr;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_ovf_set;
  logic                  w_unf_set;

  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_valid;
  logic                  r_ovf;
  logic                  r_unf;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_C);

  // Decode the request and derive memory write/read addresses from the count
  always_comb begin
    w_op      = decode_op(Push_In, Pop_In, Peek_In);
    w_we      = 1'b0;
    w_raddr   = w_empty ? '0 : ADDR_W'(r_count - CNT_W'(1));
    w_waddr   = ADDR_W'(r_count);
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    case (w_op)
      OP_PUSH: begin
        w_we      = ~w_full;
        w_ovf_set = w_full;
      end
      OP_REPLACE: begin
        w_we    = ~w_empty;
        w_waddr = w_raddr;
      end
      OP_POP, OP_PEEK: begin
        w_unf_set = w_empty;
      end
      default: ;
    endcase
  end

  lifo_mem_1w1r #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .i_clk     (Clk_In),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (Data_In),
    .i_raddr   (w_raddr),
    .o_rdata_c (w_rdata)
  );

  // Occupancy: the count doubles as the stack pointer
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      r_count <= '0;
    end else begin
      case (w_op)
        OP_PUSH: if (!w_full)  r_count <= r_count + CNT_W'(1);
        OP_POP:  if (!w_empty) r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Read data register and one-cycle valid strobe; data holds between reads
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (w_op)
        OP_POP, OP_PEEK: begin
          if (!w_empty) begin
            r_dout  <= w_rdata;
            r_valid <= 1'b1;
          end
        end
        OP_REPLACE: begin
          r_dout  <= w_empty ? Data_In : w_rdata;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~Err_Clr_In);
      r_unf <= w_unf_set | (r_unf & ~Err_Clr_In);
    end
  end

  assign Data_Out      = r_dout;
  assign Out_Valid     = r_valid;
  assign Count         = r_count;
  assign LIFO_Empty    = w_empty;
  assign LIFO_Full     = w_full;
  assign Almost_Full   = (r_count >= AF_C);
  assign Overflow_Err  = r_ovf;
  assign Underflow_Err = r_unf;

endmodule

// File: tb/tb_lifo_stack_param.sv
// Directed bench for lifo_stack_param with a queue-based stack model and output scoreboard.
module tb_lifo_stack_param;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEP   = 8;
  localparam int unsigned AFM   = 1;
  localparam int unsigned CW    = $clog2(DEP + 1);

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          push, pop, peek, clr;
  logic [DW-1:0] dout;
  logic          vld;
  logic [CW-1:0] cnt;
  logic          empty, full, afull, ovf, unf;

  int checks = 0;
  int errors = 0;

  // Reference stack, expected read outputs, and expected flag/data state
  logic [DW-1:0] stk [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] m_dout;
  logic          m_ovf, m_unf;

  lifo_stack_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEP),
    .AF_MARGIN  (AFM)
  ) dut (
    .Clk_In        (clk),
    .Reset_N_In    (rst_n),
    .Data_In       (din),
    .Push_In       (push),
    .Pop_In        (pop),
    .Peek_In       (peek),
    .Err_Clr_In    (clr),
    .Data_Out      (dout),
    .Out_Valid     (vld),
    .Count         (cnt),
    .LIFO_Empty    (empty),
    .LIFO_Full     (full),
    .Almost_Full   (afull),
    .Overflow_Err  (ovf),
    .Underflow_Err (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all observable state against the model
  task automatic check_state(input string tag);
    logic [DW-1:0] e;
    chk({tag, ":count"}, DW'(cnt), DW'(stk.size()));
    chk({tag, ":empty"}, DW'(empty), DW'(stk.size() == 0));
    chk({tag, ":full"},  DW'(full),  DW'(stk.size() == DEP));
    chk({tag, ":afull"}, DW'(afull), DW'(stk.size() >= DEP - AFM));
    chk({tag, ":ovf"},   DW'(ovf),   DW'(m_ovf));
    chk({tag, ":unf"},   DW'(unf),   DW'(m_unf));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_dout = e;
      chk({tag, ":valid"}, DW'(vld), DW'(1));
      chk({tag, ":dout"},  dout, e);
    end else begin
      chk({tag, ":valid"}, DW'(vld), DW'(0));
      chk({tag, ":hold"},  dout, m_dout);
    end
  endtask

  // Drive one cycle of requests, update the model, then sample after the edge
  task automatic do_op(input string tag, input logic p, input logic q, input logic k,
                       input logic c, input logic [DW-1:0] d);
    logic [DW-1:0] top;
    push = p; pop = q; peek = k; clr = c; din = d;
    if (c) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (p && q) begin
      if (stk.size() > 0) begin
        top = stk.pop_back();
        exp_q.push_back(top);
        stk.push_back(d);
      end else begin
        exp_q.push_back(d);
      end
    end else if (p) begin
      if (stk.size() < DEP) stk.push_back(d);
      else m_ovf = 1'b1;
    end else if (q) begin
      if (stk.size() > 0) exp_q.push_back(stk.pop_back());
      else m_unf = 1'b1;
    end else if (k) begin
      if (stk.size() > 0) exp_q.push_back(stk[stk.size()-1]);
      else m_unf = 1'b1;
    end
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; peek = 1'b0; clr = 1'b0;
    check_state(tag);
  endtask

  task automatic model_reset();
    stk.delete();
    exp_q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    din = '0; push = 1'b0; pop = 1'b0; peek = 1'b0; clr = 1'b0;
    model_reset();
    #12;
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: push three, pop three
    do_op("t1_push11", 1, 0, 0, 0, 32'h11);
    do_op("t1_push22", 1, 0, 0, 0, 32'h22);
    do_op("t1_push33", 1, 0, 0, 0, 32'h33);
    do_op("t1_pop",    0, 1, 0, 0, '0);
    do_op("t1_pop",    0, 1, 0, 0, '0);
    do_op("t1_pop",    0, 1, 0, 0, '0);
    do_op("t1_idle",   0, 0, 0, 0, '0);

    // 2: fill, overflow, pop returns last real word
    for (int i = 0; i < DEP; i++) do_op("t2_fill", 1, 0, 0, 0, 32'h100 + DW'(i));
    do_op("t2_ovf",    1, 0, 0, 0, 32'hDEAD);
    do_op("t2_replace_full", 1, 1, 0, 0, 32'h777);
    do_op("t2_pop",    0, 1, 0, 0, '0);
    do_op("t2_peek",   0, 0, 1, 0, '0);
    do_op("t2_ovf_clr_set", 1, 0, 0, 1, 32'h5);
    do_op("t2_ovf_again", 1, 0, 0, 0, 32'h6);
    do_op("t2_clr",    0, 0, 0, 1, '0);
    while (stk.size() > 0) do_op("t2_drain", 0, 1, 0, 0, '0);

    // 3: underflow from reset state
    rst_n = 1'b0;
    model_reset();
    #1;
    check_state("t3_reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_op("t3_pop_empty",  0, 1, 0, 0, '0);
    do_op("t3_peek_empty", 0, 0, 1, 0, '0);
    do_op("t3_clr",        0, 0, 0, 1, '0);

    // 4: replace-top
    do_op("t4_pushA",   1, 0, 0, 0, 32'hA);
    do_op("t4_pushB",   1, 0, 0, 0, 32'hB);
    do_op("t4_replC",   1, 1, 0, 0, 32'hC);
    do_op("t4_popC",    0, 1, 0, 0, '0);
    do_op("t4_popA",    0, 1, 0, 0, '0);

    // 5: pass-through on empty
    do_op("t5_pass",    1, 1, 0, 0, 32'h55);
    do_op("t5_idle",    0, 0, 0, 0, '0);

    // Back-to-back push then pop with no bubble
    do_op("bb_push",    1, 0, 0, 0, 32'hBEEF);
    do_op("bb_pop",     0, 1, 0, 0, '0);

    // 6: asynchronous reset while a pop is pending
    do_op("t6_push",    1, 0, 0, 0, 32'h61);
    do_op("t6_push",    1, 0, 0, 0, 32'h62);
    do_op("t6_push",    1, 0, 0, 0, 32'h63);
    do_op("t6_pop",     0, 1, 0, 0, '0);
    pop = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("t6_async_rst");
    @(posedge clk);
    #1;
    pop = 1'b0;
    check_state("t6_held_rst");
    @(negedge clk);
    rst_n = 1'b1;
    do_op("t6_pop_after", 0, 1, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
